// File: rtl/irq_controller.sv
// Interrupt aggregator: timer, software and NUM_SRC gated external sources with claim/complete.
// Define IRQC_EDGE_EN to add the EDGE_SEL register and per-source rising-edge triggering.

module irq_gateway (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
`ifdef IRQC_EDGE_EN
  input  logic edge_sel,
`endif
  input  logic claim,
  input  logic complete,
  output logic pending
);
  typedef enum logic [1:0] {IDLE, PEND, CLMD} gw_state_t;

  gw_state_t state, state_nxt;
  logic      meta, sync, trig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= src;
      sync <= meta;
    end
  end

`ifdef IRQC_EDGE_EN
  logic sync_prev;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_prev <= 1'b0;
    else        sync_prev <= sync;
  end
  // An edge that lands outside IDLE is a one-cycle pulse, so it is simply lost.
  assign trig = edge_sel ? (sync & ~sync_prev) : sync;
`else
  assign trig = sync;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trig)     state_nxt = PEND;
      PEND:    if (claim)    state_nxt = CLMD;
      CLMD:    if (complete) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pending = (state == PEND);
  end
endmodule

module irq_controller #(
  parameter int          NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h4000_5000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic               re,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               timer_irq,
  output logic               mtip,
  output logic               msip,
  output logic               meip
);
  logic [NUM_SRC:1] pending, enable;
  logic [4:0]       claim_id;
  logic             sel_pend, sel_en, sel_claim, sel_msip, claim_fire;
  logic             unused_wdata;

  assign sel_pend   = (addr == BASE_ADDR);
  assign sel_en     = (addr == BASE_ADDR + 32'h4);
  assign sel_claim  = (addr == BASE_ADDR + 32'h8);
  assign sel_msip   = (addr == BASE_ADDR + 32'hC);
  assign claim_fire = re && sel_claim && (claim_id != 5'd0);
  assign unused_wdata = ^wdata;

`ifdef IRQC_EDGE_EN
  logic             sel_edge;
  logic [NUM_SRC:1] edge_sel;
  assign sel_edge = (addr == BASE_ADDR + 32'h10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                edge_sel <= '0;
    else if (we && sel_edge)   edge_sel <= wdata[NUM_SRC:1];
  end
`endif

  for (genvar g = 1; g <= NUM_SRC; g++) begin : g_src
    irq_gateway u_gw (
      .clk      (clk),
      .rst_n    (rst_n),
      .src      (src_irq[g-1]),
`ifdef IRQC_EDGE_EN
      .edge_sel (edge_sel[g]),
`endif
      .claim    (claim_fire && (claim_id == 5'(g))),
      .complete (we && sel_claim && (wdata[4:0] == 5'(g))),
      .pending  (pending[g])
    );
  end

  // Lowest ID wins; uses the pre-edge ENABLE so a concurrent write cannot race the claim.
  always_comb begin
    claim_id = '0;
    for (int i = NUM_SRC; i >= 1; i--)
      if (pending[i] && enable[i]) claim_id = 5'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable <= '0;
      msip   <= 1'b0;
      mtip   <= 1'b0;
      meip   <= 1'b0;
    end else begin
      if (we && sel_en)   enable <= wdata[NUM_SRC:1];
      if (we && sel_msip) msip   <= wdata[0];
      mtip <= timer_irq;
      meip <= |(pending & enable);
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_pend)       rdata[NUM_SRC:1] = pending;
    else if (sel_en)    rdata[NUM_SRC:1] = enable;
    else if (sel_claim) rdata[4:0]       = claim_id;
    else if (sel_msip)  rdata[0]         = msip;
`ifdef IRQC_EDGE_EN
    else if (sel_edge)  rdata[NUM_SRC:1] = edge_sel;
`endif
  end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt aggregator that sits directly downstream of the machine timer. It collects the timer's level irq, NUM_SRC external peripheral interrupt lines and a software interrupt bit.
- It presents registered mtip/msip/meip lines to the core's CSR/trap logic.
- External sources go through a per-source gateway: synchroniser, pending latch, and a claim/complete handshake over the data bus.

Parameters:
- NUM_SRC, 8, number of external interrupt sources; legal range 1..31; source IDs are 1..NUM_SRC, ID 0 means "none".
- BASE_ADDR, 32'h40005000, base of the 5-word register window.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- we  input  1  bus write strobe
- re  input  1  bus read strobe; qualifies read side effects only
- addr  input  32  byte address, word aligned
- wdata  input  32  write data
- rdata  output  32  read data, combinational from addr
- src_irq  input  NUM_SRC  asynchronous level interrupt lines from peripherals
- timer_irq  input  1  level irq from machine timer
- mtip  output  1  registered timer_irq
- msip  output  1  software interrupt, equals MSIP[0]
- meip  output  1  registered OR of (pending & enable)

Behaviour:
- Register map, offsets from BASE_ADDR:
  - +0x00 PENDING: RO. Bits [NUM_SRC:1] = pending; bit 0 and unused bits read 0.
  - +0x04 ENABLE: RW, same bit layout; bit 0 and bits above NUM_SRC are not stored and read 0.
  - +0x08 CLAIM/COMPLETE: read = claim, write = complete.
  - +0x0C MSIP: RW bit 0.
  - +0x10 EDGE_SEL: see Optional Feature.
  - Any other address reads 0; writes to it are ignored.
- Reset values: PENDING, ENABLE, claimed flags, MSIP, synchronisers all 0. mtip = msip = meip = 0.
- Synchroniser: 2 flops per src_irq bit, giving sync[i].
- Per-source gateway states:
  - IDLE -> PENDING when level mode and sync[i]=1.
  - PENDING -> CLAIMED on a claim selecting i: pending[i] cleared, claimed[i] set on the same edge.
  - CLAIMED -> IDLE on a complete write with wdata[4:0]==i while claimed[i]=1.
  - A source in PENDING or CLAIMED ignores further assertion.
  - After complete, if the level is still high, the source re-pends on the next edge.
- Latency: src_irq rises just before edge 1 -> sync at edge 2 -> pending at edge 3 -> meip at edge 4 (if enabled).
- Claim read:
  - rdata = ID of the lowest-numbered source with pending & enable, else 0. Computed from pre-edge state.
  - The side effect occurs only on an edge where re=1 and addr==CLAIM and the ID is nonzero.
  - A claim returning 0 has no effect.
- Complete write:
  - Takes effect only when 1<=wdata[4:0]<=NUM_SRC and that source is claimed.
  - Otherwise it is silently ignored; wdata[31:5] is ignored.
- Simultaneous events:
  - A claim and a new assertion on a different source in the same cycle both take effect.
  - An ENABLE write concurrent with a claim: the claim uses the old ENABLE.
  - A complete and a claim in the same cycle cannot occur (single bus port).
- A disabled pending source stays pending and is not claimable. Enabling it later raises meip one edge after the write.
- mtip: timer_irq registered 1 cycle; no gating.
- msip: driven directly from the MSIP register bit.
- Reset mid-operation: all state clears immediately (asynchronous); claimed sources return to IDLE.

Optional Feature:
- Macro: IRQC_EDGE_EN.
- Defined:
  - EDGE_SEL at +0x10 is RW, same bit layout as ENABLE; reset 0.
  - Source with EDGE_SEL[i]=1: IDLE -> PENDING on a synchronised rising edge (sync[i]=1 and the previous sampled value was 0).
  - An edge arriving while PENDING or CLAIMED is dropped.
  - Complete does not re-pend on a held-high level.
- Not defined: all sources are level mode; +0x10 reads 0 and writes are ignored; no edge-detect flops are instantiated.

Test Plan:
- Reset, then read all 5 registers -> all 0; mtip=msip=meip=0; claim read returns 0.
- ENABLE=0x00000004; raise src_irq[1] (ID 2) -> PENDING=0x4 at edge 3, meip=1 at edge 4. Claim returns 2, PENDING=0, meip=0. Complete wdata=2 with line still high -> re-pends next edge.
- ENABLE=0x1FE; assert IDs 3 and 5 together -> claim returns 3, then 5, then 0. Complete with wdata=7 (not claimed) leaves claimed flags unchanged.
- ID 4 pending with ENABLE=0 -> meip=0 and claim returns 0. Write ENABLE=0x10 -> meip=1 one edge later.
- timer_irq toggled -> mtip follows 1 cycle later. Write MSIP=1 -> msip=1; write 0 -> msip=0.
- With IRQC_EDGE_EN, EDGE_SEL=0x2: pulse ID 1 twice while claimed -> only one claim returns 1; after complete, a held-high line does not re-pend.
